// File: rtl/ps2_key_event_fifo.sv
// PS/2 key event builder and buffer.
// Turns the receiver's keycode bytes into single make/break events. The E0
// (extended) and F0 (break) prefixes are folded into each event. The block
// also tracks the shift/ctrl modifier state and queues events in a
// first-word-fall-through FIFO, which the bus controller drains with a
// valid/ready handshake.
module ps2_key_event_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      keycode,
    input  logic             keycode_valid,
    output logic [9:0]       event_data,
    output logic             event_valid,
    input  logic             event_ready,
    output logic [CNT_W-1:0] fifo_count,
    output logic [3:0]       modifiers,
    output logic             overflow,
    input  logic             overflow_clr
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        CLS_IDLE,   // no new byte this cycle
        CLS_EXT,    // bare E0 prefix
        CLS_BRK,    // F0 break prefix, optionally carrying E0 in the high byte
        CLS_ERR,    // 00/FF receiver error or overrun byte
        CLS_CODE    // real scan code; forms an event
    } byte_cls_e;

    logic            prev_valid;
    logic            ext_pend;
    logic            brk_pend;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [9:0]      mem [DEPTH];

    logic            stb;
    logic            hi_e0;
    byte_cls_e       cls;
    logic [9:0]      new_event;
    logic            fifo_full;
    logic            do_pop;
    logic            do_push;
    logic            drop;
    logic [3:0]      mods_next;

    // Detect the rising edge of the multi-cycle receiver strobe.
    assign stb   = keycode_valid & ~prev_valid;
    assign hi_e0 = (keycode[15:8] == 8'hE0);

    // Classify the byte that arrived this cycle, in priority order.
    always_comb begin
        // NOTE: assign every always_comb output a default first, so that no path can infer a latch.
        cls = CLS_IDLE;
        if (stb) begin
            if (keycode == 16'hE000)
                cls = CLS_EXT;
            else if (keycode[7:0] == 8'hF0)
                cls = CLS_BRK;
            else if (keycode[7:0] == 8'h00 || keycode[7:0] == 8'hFF)
                cls = CLS_ERR;
            else
                cls = CLS_CODE;
        end
    end

    assign new_event   = {brk_pend, ext_pend | hi_e0, keycode[7:0]};
    assign fifo_full   = (fifo_count == CNT_W'(DEPTH));
    assign event_valid = (fifo_count != '0);
    assign do_pop      = event_valid & event_ready;
    // A pop frees a slot in the same cycle, so a push to a full FIFO still fits.
    assign do_push     = (cls == CLS_CODE) & (~fifo_full | do_pop);
    assign drop        = (cls == CLS_CODE) & fifo_full & ~do_pop;
    assign event_data  = mem[rd_ptr];

    // Work out the modifier state from every formed event, including dropped ones.
    always_comb begin
        mods_next = modifiers;
        if (cls == CLS_CODE) begin
            case ({new_event[8], new_event[7:0]})
                {1'b0, 8'h12}: mods_next[0] = ~new_event[9];
                {1'b0, 8'h59}: mods_next[1] = ~new_event[9];
                {1'b0, 8'h14}: mods_next[2] = ~new_event[9];
                {1'b1, 8'h14}: mods_next[3] = ~new_event[9];
                default:       mods_next = modifiers;
            endcase
        end
    end

    // Control state: the prefix flags, the pointers, the count, the modifiers and sticky overflow.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
        if (rst) begin
            prev_valid <= 1'b1;     // ignore a strobe that is already high when reset deasserts
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            modifiers  <= '0;
            overflow   <= 1'b0;
        end else begin
            prev_valid <= keycode_valid;
            modifiers  <= mods_next;

            case (cls)
                CLS_EXT:  ext_pend <= 1'b1;
                CLS_BRK: begin
                    brk_pend <= 1'b1;
                    ext_pend <= ext_pend | hi_e0;
                end
                CLS_ERR, CLS_CODE: begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
                default: ;
            endcase

            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);

            if (do_push && !do_pop)
                fifo_count <= fifo_count + CNT_W'(1);
            else if (do_pop && !do_push)
                fifo_count <= fifo_count - CNT_W'(1);

            // A new drop takes priority over a clear in the same cycle.
            if (drop)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end

    // Event storage; cleared on reset so that event_data reads zero afterwards.
    always_ff @(posedge clk) begin
        // NOTE: the storage is reset here only because event_data must read 0 out of reset; a FIFO RAM normally needs no reset.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= new_event;
        end
    end

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Self-checking bench for ps2_key_event_fifo: directed scenarios plus a
// randomized byte stream checked against a queue-based event model.
module tb_ps2_key_event_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      keycode;
    logic             keycode_valid;
    logic [9:0]       event_data;
    logic             event_valid;
    logic             event_ready;
    logic [CNT_W-1:0] fifo_count;
    logic [3:0]       modifiers;
    logic             overflow;
    logic             overflow_clr;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [9:0] q[$];
    logic       m_ext, m_brk, m_ovf;
    logic [3:0] m_mods;

    ps2_key_event_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .keycode(keycode), .keycode_valid(keycode_valid),
        .event_data(event_data), .event_valid(event_valid), .event_ready(event_ready),
        .fifo_count(fifo_count), .modifiers(modifiers), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_mods = 4'b0;
    endtask

    // Apply one received byte to the model, together with the consumer's ready and clear inputs.
    task automatic model_byte(input logic [15:0] kc, input logic rdy, input logic clr);
        logic [9:0] ev;
        logic       dropped;
        logic       hi;
        dropped = 0;
        hi = (kc[15:8] == 8'hE0);
        if (rdy && q.size() != 0) void'(q.pop_front());
        if (kc == 16'hE000) m_ext = 1;
        else if (kc[7:0] == 8'hF0) begin m_brk = 1; m_ext = m_ext | hi; end
        else if (kc[7:0] == 8'h00 || kc[7:0] == 8'hFF) begin m_ext = 0; m_brk = 0; end
        else begin
            ev = {m_brk, m_ext | hi, kc[7:0]};
            if (!ev[8] && ev[7:0] == 8'h12) m_mods[0] = ~ev[9];
            if (!ev[8] && ev[7:0] == 8'h59) m_mods[1] = ~ev[9];
            if (!ev[8] && ev[7:0] == 8'h14) m_mods[2] = ~ev[9];
            if ( ev[8] && ev[7:0] == 8'h14) m_mods[3] = ~ev[9];
            if (q.size() < DEPTH) q.push_back(ev);
            else begin dropped = 1; m_ovf = 1; end
            m_ext = 0; m_brk = 0;
        end
        if (!dropped && clr) m_ovf = 0;
    endtask

    // Present one byte with valid held for 'hold' cycles. rdy and clr are applied only in the strobe cycle.
    task automatic send(input logic [15:0] kc, input int hold, input logic rdy, input logic clr);
        keycode = kc; keycode_valid = 1; event_ready = rdy; overflow_clr = clr;
        if (rdy && q.size() != 0) begin
            checks++;
            if (event_data !== q[0]) begin
                errors++; $display("FAIL pop_head: got %h expected %h", event_data, q[0]);
            end
        end
        model_byte(kc, rdy, clr);
        @(negedge clk);
        event_ready = 0; overflow_clr = 0;
        repeat (hold - 1) @(negedge clk);
        keycode_valid = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; keycode_valid = 0; keycode = 16'h0; event_ready = 0; overflow_clr = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        model_clear();
        @(negedge clk);
    endtask

    // Pop every modelled event, comparing each head value; bounded by the model depth.
    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 4 * DEPTH) begin
            checks++;
            if (event_data !== q[0] || event_valid !== 1'b1) begin
                errors++; $display("FAIL drain_head: got %h/%b expected %h/1", event_data, event_valid, q[0]);
            end
            event_ready = 1;
            @(negedge clk);
            void'(q.pop_front());
            guard++;
        end
        event_ready = 0;
        checks++;
        if (fifo_count !== '0 || event_valid !== 1'b0) begin
            errors++; $display("FAIL drain_empty: got count %0d valid %b expected 0/0", fifo_count, event_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({event_data, event_valid, fifo_count, modifiers, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_state: got data %h valid %b count %0d mods %b ovf %b expected all 0",
                     event_data, event_valid, fifo_count, modifiers, overflow);
        end
    endtask

    task automatic test_single_make();
        keycode = 16'h001C; keycode_valid = 1;
        model_byte(16'h001C, 0, 0);
        @(negedge clk);
        checks++;
        if (event_valid !== 1'b1 || fifo_count !== 4'd1) begin
            errors++; $display("FAIL make_latency: got valid %b count %0d expected 1/1", event_valid, fifo_count);
        end
        @(negedge clk);
        keycode_valid = 0;
        @(negedge clk);
        checks++;
        if (fifo_count !== 4'd1 || event_data !== 10'h01C) begin
            errors++; $display("FAIL make_single: got count %0d data %h expected 1/01c", fifo_count, event_data);
        end
        drain();
    endtask

    task automatic test_break();
        send(16'h00F0, 2, 0, 0);
        checks++;
        if (event_valid !== 1'b0) begin
            errors++; $display("FAIL break_prefix_no_event: got valid %b expected 0", event_valid);
        end
        send(16'h001C, 1, 0, 0);
        checks++;
        if (fifo_count !== 4'd1 || event_data !== 10'h21C) begin
            errors++; $display("FAIL break_event: got count %0d data %h expected 1/21c", fifo_count, event_data);
        end
        drain();
    endtask

    task automatic test_ext_break();
        send(16'hE000, 1, 0, 0);
        send(16'hE0F0, 3, 0, 0);
        send(16'h0075, 2, 0, 0);
        checks++;
        if (fifo_count !== 4'd1 || event_data !== 10'h375) begin
            errors++; $display("FAIL ext_break: got count %0d data %h expected 1/375", fifo_count, event_data);
        end
        drain();
    endtask

    task automatic test_modifiers();
        send(16'h0012, 1, 0, 0);
        checks++;
        if (modifiers !== 4'b0001) begin
            errors++; $display("FAIL mods_lshift: got %b expected 0001", modifiers);
        end
        send(16'hE000, 1, 0, 0);
        send(16'hE014, 1, 0, 0);
        checks++;
        if (modifiers !== 4'b1001) begin
            errors++; $display("FAIL mods_rctrl: got %b expected 1001", modifiers);
        end
        send(16'h00F0, 1, 0, 0);
        send(16'h0012, 1, 0, 0);
        checks++;
        if (modifiers !== 4'b1000) begin
            errors++; $display("FAIL mods_lshift_break: got %b expected 1000", modifiers);
        end
        drain();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) send(16'(i), 1, 0, 0);
        checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_fill: got count %0d ovf %b expected 8/1", fifo_count, overflow);
        end
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (event_data !== 10'(i)) begin
                errors++; $display("FAIL ovf_order: got %h expected %h", event_data, 10'(i));
            end
            event_ready = 1;
            @(negedge clk);
            void'(q.pop_front());
        end
        event_ready = 0;
        checks++;
        if (fifo_count !== 4'd0) begin
            errors++; $display("FAIL ovf_drained: got count %0d expected 0", fifo_count);
        end
        for (int i = 0; i < 8; i++) send(16'h0011 + 16'(i), 1, 0, 0);
        send(16'h0019, 1, 1, 0);
        checks++;
        if (fifo_count !== 4'd8 || event_data !== 10'h012 || q.size() != 8 || q[7] !== 10'h019) begin
            errors++; $display("FAIL full_push_pop: got count %0d head %h expected 8/012", fifo_count, event_data);
        end
        overflow_clr = 1; @(negedge clk); overflow_clr = 0; m_ovf = 0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
        send(16'h001A, 1, 0, 1);
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 4'd8) begin
            errors++; $display("FAIL ovf_set_wins: got ovf %b count %0d expected 1/8", overflow, fifo_count);
        end
        drain();
        overflow_clr = 1; @(negedge clk); overflow_clr = 0; m_ovf = 0;
    endtask

    task automatic test_reset_midstream();
        send(16'h0012, 1, 0, 0);
        send(16'h0033, 1, 0, 0);
        send(16'h0034, 1, 0, 0);
        send(16'h00F0, 1, 0, 0);
        rst = 1; keycode = 16'h001C; keycode_valid = 1;
        repeat (2) @(negedge clk);
        model_clear();
        checks++;
        if ({event_data, event_valid, fifo_count, modifiers, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got data %h valid %b count %0d mods %b ovf %b expected all 0",
                     event_data, event_valid, fifo_count, modifiers, overflow);
        end
        rst = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (event_valid !== 1'b0 || fifo_count !== 4'd0) begin
            errors++; $display("FAIL reset_held_valid: got valid %b count %0d expected 0/0", event_valid, fifo_count);
        end
        keycode_valid = 0;
        @(negedge clk);
        send(16'h001C, 1, 0, 0);
        checks++;
        if (fifo_count !== 4'd1 || event_data !== 10'h01C) begin
            errors++; $display("FAIL reset_brk_cleared: got count %0d data %h expected 1/01c", fifo_count, event_data);
        end
        drain();
    endtask

    task automatic test_random();
        logic [15:0] kc;
        logic [7:0]  lo;
        int          kind;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0: lo = 8'h12;
                1: lo = 8'h59;
                2: lo = 8'h14;
                default: lo = 8'($urandom);
            endcase
            case (kind)
                0:       kc = 16'hE000;
                1, 2:    kc = {($urandom_range(0, 1) == 1) ? 8'hE0 : 8'h00, 8'hF0};
                3:       kc = {8'h00, ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00};
                default: kc = {($urandom_range(0, 3) == 0) ? 8'hE0 : 8'h00, lo};
            endcase
            send(kc, $urandom_range(1, 3), $urandom_range(0, 9) < 4, $urandom_range(0, 7) == 0);
            checks++;
            if (fifo_count !== CNT_W'(q.size()) || event_valid !== (q.size() != 0) ||
                (q.size() != 0 && event_data !== q[0]) || modifiers !== m_mods || overflow !== m_ovf) begin
                errors++;
                $display("FAIL random_step %0d: got count %0d valid %b data %h mods %b ovf %b expected %0d/%b/%h/%b/%b",
                         n, fifo_count, event_valid, event_data, modifiers, overflow,
                         q.size(), q.size() != 0, (q.size() != 0) ? q[0] : 10'h0, m_mods, m_ovf);
            end
            if ($urandom_range(0, 24) == 0) drain();
        end
        drain();
    endtask

    initial begin
        rst = 1; keycode = 16'h0; keycode_valid = 0; event_ready = 0; overflow_clr = 0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_single_make();
        test_break();
        test_ext_break();
        test_modifiers();
        test_overflow();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_fifo.md
Name: ps2_key_event_fifo

Overview:
- Sits directly downstream of the PS/2 receiver in the keyboard peripheral, on the system clock.
- Consumes the receiver's 16-bit keycode and its multi-cycle valid strobe.
- Resolves the E0 (extended) and F0 (break) prefix bytes into single make/break key events.
- Tracks modifier key state and buffers events in a FIFO that the peripheral bus controller drains with a valid/ready handshake.

Parameters:
- DEPTH, 8, number of FIFO entries; power of 2, minimum 2.
- CNT_W, 4, width of fifo_count; equals log2(DEPTH)+1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- keycode  input  16  receiver keycode; [15:8] is the E0 prefix when present, [7:0] is the last received byte.
- keycode_valid  input  1  receiver strobe; may stay high for several cycles per byte.
- event_data  output  10  head event: {release, extended, code[7:0]}.
- event_valid  output  1  FIFO is not empty.
- event_ready  input  1  consumer accepts the head event.
- fifo_count  output  CNT_W  number of stored events, 0 to DEPTH.
- modifiers  output  4  {rctrl, lctrl, rshift, lshift}.
- overflow  output  1  sticky; set when an event is dropped because the FIFO is full.
- overflow_clr  input  1  clears overflow.

Behaviour:
- Reset values: event_data 0, event_valid 0, fifo_count 0, modifiers 0, overflow 0.
- Reset also clears the read/write pointers, ext_pend and brk_pend.
- Reset sets prev_valid to 1, so a keycode_valid pulse that is already high when reset deasserts is ignored.
- Byte strobe: stb = keycode_valid & ~prev_valid; prev_valid <= keycode_valid every cycle. Exactly one byte is processed per rising edge of keycode_valid, however long it stays high.
- Classification on a cycle with stb=1, in priority order:
  1. keycode == 16'hE000: ext_pend <= 1; no event.
  2. keycode[7:0] == 8'hF0: brk_pend <= 1; ext_pend <= ext_pend | (keycode[15:8] == 8'hE0); no event.
  3. keycode[7:0] == 8'h00 or 8'hFF (error/overrun): clear ext_pend and brk_pend; no event.
  4. Otherwise, a code byte: form the event {brk_pend, ext_pend | (keycode[15:8] == 8'hE0), keycode[7:0]}, push it, then clear ext_pend and brk_pend.
- Push latency: a stb in cycle N writes the FIFO at the end of cycle N; event_valid and fifo_count reflect it from cycle N+1.
- FIFO is first-word-fall-through: event_data is always the entry at the read pointer. It is don't-care when event_valid=0; in simulation it holds the last value.
- Pop occurs when event_valid & event_ready.
- Pointers wrap modulo DEPTH.
- fifo_count: +1 on push only, −1 on pop only, unchanged when push and pop happen in the same cycle.
- Full FIFO with push and pop in the same cycle: both are performed and no overflow is raised.
- Full FIFO with push and no pop: the event is dropped and overflow <= 1.
- Empty FIFO: event_ready is ignored and there is no underflow.
- overflow_clr and a new drop in the same cycle: the set wins, overflow = 1.
- Modifier tracking updates on every formed code event, including events dropped by a full FIFO. New value = ~release.
  - Code 0x12, not extended: lshift.
  - Code 0x59, not extended: rshift.
  - Code 0x14, not extended: lctrl.
  - Code 0x14, extended: rctrl.
  - All other codes leave modifiers unchanged.
- Reset mid-stream discards any partially received prefix and all buffered events.

Test Plan:
1. Single make: keycode=16'h001C with valid held high for 2 cycles. Required: exactly one event, event_data=10'h01C, fifo_count=1, event_valid rises 1 cycle after the valid edge.
2. Break sequence: 16'h00F0, then 16'h001C. Required: one event 10'h21C; no event for the F0 byte.
3. Extended break, three strobes: 16'hE000, then 16'hE0F0, then 16'h0075. Required: a single event 10'h375.
4. Modifier tracking: make 0x12 → modifiers=4'b0001. E0-prefixed make 0x14 → modifiers=4'b1001. Break 0x12 → modifiers=4'b1000.
5. Overflow (DEPTH=8), with event_ready=0:
   - Push 9 codes 0x01..0x09. Required: fifo_count=8, overflow=1, and draining yields 0x01..0x08 in order.
   - Push at full with event_ready=1 in the same cycle. Required: no drop, count stays 8.
6. Reset handling:
   - Assert rst with 3 events queued and brk_pend set. Required: all outputs 0.
   - Release rst while keycode_valid=1. Required: no event is produced.
   - Next code 0x1C. Required: event 10'h01C, confirming the break prefix was cleared.
